// File: rtl/delay_and_sum.sv
// Delay-and-sum beamformer: stores each frame into per-channel circular history,
// then sums every channel read back at its own integer sample delay.
module delay_and_sum #(
    parameter int unsigned BIT_WIDTH = 24,
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned MAX_DELAY = 32,
    parameter int unsigned DELAY_W   = $clog2(MAX_DELAY),
    parameter int unsigned SUM_W     = BIT_WIDTH + $clog2(SLOTS)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [BIT_WIDTH-1:0]        audio_in [SLOTS],
    input  logic                        audio_valid_in,
    input  logic [DELAY_W-1:0]          delay_in [SLOTS],
    input  logic                        delay_load_in,
    output logic signed [SUM_W-1:0]     sum_out,
    output logic                        sum_valid_out,
    output logic                        ready_out,
    output logic                        overrun_out
);

    localparam int unsigned CNT_W = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM
    } state_t;

    state_t state, state_nxt;

    logic [DELAY_W-1:0]      wr_ptr;
    logic [DELAY_W-1:0]      frame_ptr;
    logic [CNT_W-1:0]        cnt;
    logic signed [SUM_W-1:0] acc;
    logic [DELAY_W-1:0]      pend_delay [SLOTS];
    logic [DELAY_W-1:0]      act_delay  [SLOTS];
    logic [BIT_WIDTH-1:0]    mem        [SLOTS][MAX_DELAY];
    logic [BIT_WIDTH-1:0]    rd_q       [SLOTS];
    logic [DELAY_W-1:0]      rd_addr_c  [SLOTS];

    logic                    accept_c;
    logic                    drop_c;
    logic                    mem_we_c;
    logic                    add_en_c;
    logic                    last_c;
    logic [BIT_WIDTH-1:0]    rd_sel_c;
    logic signed [SUM_W-1:0] add_sample_c;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (wr_ptr == DELAY_W'(MAX_DELAY - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  if (audio_valid_in)                    state_nxt = ST_ACCUM;
            ST_ACCUM: if (cnt == CNT_W'(SLOTS))              state_nxt = ST_IDLE;
            default:                                         state_nxt = ST_CLEAR;
        endcase
    end

    // Control decode; the sample added at step cnt is the one read at step cnt-1
    always_comb begin
        accept_c = (state == ST_IDLE) && audio_valid_in;
        drop_c   = (state != ST_IDLE) && audio_valid_in;
        mem_we_c = !rst_in && ((state == ST_CLEAR) || accept_c);
        add_en_c = (state == ST_ACCUM) && (cnt != '0);
        last_c   = (state == ST_ACCUM) && (cnt == CNT_W'(SLOTS));
        rd_sel_c = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (cnt == CNT_W'(k + 1)) rd_sel_c = rd_q[k];
            rd_addr_c[k] = frame_ptr - act_delay[k];
        end
        add_sample_c = SUM_W'($signed(rd_sel_c));
    end

    // History memories: CLEAR zero-fills using wr_ptr as the sweep address
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (mem_we_c) mem[i][wr_ptr] <= (state == ST_CLEAR) ? '0 : audio_in[i];
            rd_q[i] <= mem[i][rd_addr_c[i]];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr        <= '0;
            frame_ptr     <= '0;
            cnt           <= '0;
            acc           <= '0;
            sum_out       <= '0;
            sum_valid_out <= 1'b0;
            ready_out     <= 1'b0;
            overrun_out   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                pend_delay[i] <= '0;
                act_delay[i]  <= '0;
            end
        end else begin
            sum_valid_out <= 1'b0;
            ready_out     <= (state_nxt == ST_IDLE);
            if (drop_c) overrun_out <= 1'b1;
            if (delay_load_in) begin
                for (int i = 0; i < SLOTS; i++) pend_delay[i] <= delay_in[i];
            end
            if ((state == ST_CLEAR) || accept_c) wr_ptr <= wr_ptr + DELAY_W'(1);
            if (accept_c) begin
                frame_ptr <= wr_ptr;
                cnt       <= '0;
                acc       <= '0;
                for (int i = 0; i < SLOTS; i++)
                    act_delay[i] <= delay_load_in ? delay_in[i] : pend_delay[i];
            end else if (state == ST_ACCUM) begin
                cnt <= cnt + CNT_W'(1);
                if (add_en_c) acc <= acc + add_sample_c;
            end
            if (last_c) begin
                sum_out       <= acc + add_sample_c;
                sum_valid_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_and_sum.sv
// Directed self-checking bench for delay_and_sum: reset timing, sums, delays,
// wrap-around, overrun and reset abort.
module tb_delay_and_sum;

    localparam int unsigned BIT_WIDTH = 24;
    localparam int unsigned SLOTS     = 4;
    localparam int unsigned DELAY_W   = 5;
    localparam int unsigned SUM_W     = 26;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [BIT_WIDTH-1:0]    audio_in [SLOTS];
    logic                    audio_valid_in;
    logic [DELAY_W-1:0]      delay_in [SLOTS];
    logic                    delay_load_in;
    logic signed [SUM_W-1:0] sum_out;
    logic                    sum_valid_out;
    logic                    ready_out;
    logic                    overrun_out;

    int checks = 0;
    int errors = 0;

    delay_and_sum dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (audio_in),
        .audio_valid_in (audio_valid_in),
        .delay_in       (delay_in),
        .delay_load_in  (delay_load_in),
        .sum_out        (sum_out),
        .sum_valid_out  (sum_valid_out),
        .ready_out      (ready_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_audio(input int a0, input int a1, input int a2, input int a3);
        audio_in[0] = BIT_WIDTH'(a0);
        audio_in[1] = BIT_WIDTH'(a1);
        audio_in[2] = BIT_WIDTH'(a2);
        audio_in[3] = BIT_WIDTH'(a3);
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        delay_in[0] = DELAY_W'(d0);
        delay_in[1] = DELAY_W'(d1);
        delay_in[2] = DELAY_W'(d2);
        delay_in[3] = DELAY_W'(d3);
    endtask

    task automatic load_delays(input int d0, input int d1, input int d2, input int d3);
        set_delays(d0, d1, d2, d3);
        delay_load_in = 1'b1;
        tick();
        delay_load_in = 1'b0;
    endtask

    // Leaves the bench in the first non-reset cycle
    task automatic do_reset();
        rst_in         = 1'b1;
        audio_valid_in = 1'b0;
        delay_load_in  = 1'b0;
        repeat (3) tick();
        rst_in = 1'b0;
    endtask

    // Sends one frame when ready, returns the sum and its latency in cycles
    task automatic run_frame(input int a0, input int a1, input int a2, input int a3,
                             input bit ld, output longint s, output int lat);
        int guard = 0;
        while (!ready_out && guard < 100) begin
            tick();
            guard++;
        end
        if (!ready_out) check("ready_timeout", 0, 1);
        set_audio(a0, a1, a2, a3);
        audio_valid_in = 1'b1;
        delay_load_in  = ld;
        tick();
        audio_valid_in = 1'b0;
        delay_load_in  = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (sum_valid_out) begin
                lat = c;
                break;
            end
            tick();
        end
        s = longint'(sum_out);
        tick();
        if (sum_valid_out) check("valid_width", 1, 0);
    endtask

    initial begin
        longint s;
        int     lat;
        int     first_ready;
        bit     bad_valid;
        bit     bad_ovr;

        set_audio(0, 0, 0, 0);
        set_delays(0, 0, 0, 0);

        // Reset release timing
        do_reset();
        first_ready = -1;
        bad_valid   = 1'b0;
        bad_ovr     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ready_out && first_ready < 0) first_ready = c;
            if (sum_valid_out) bad_valid = 1'b1;
            if (overrun_out)   bad_ovr   = 1'b1;
            if (c == 0) check("reset_sum", longint'(sum_out), 0);
            tick();
        end
        check("ready_after_reset", first_ready, 32);
        check("reset_no_valid", bad_valid, 0);
        check("reset_no_overrun", bad_ovr, 0);

        // Zero delays
        run_frame(1, 2, 3, 4, 1'b0, s, lat);
        check("sum_1234", s, 10);
        check("latency", lat, 6);
        run_frame(24'h800000, 24'h800000, 24'h800000, 24'h800000, 1'b0, s, lat);
        check("sum_min", s, -33554432);
        run_frame(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, s, lat);
        check("sum_max", s, 33554428);

        // Staggered delays, impulse response
        do_reset();
        load_delays(0, 1, 2, 3);
        run_frame(100, 100, 100, 100, 1'b0, s, lat);
        check("imp_f0", s, 100);
        for (int f = 1; f <= 4; f++) begin
            run_frame(0, 0, 0, 0, 1'b0, s, lat);
            check($sformatf("imp_f%0d", f), s, (f < 4) ? 100 : 0);
        end

        // Maximum delay with pointer wrap
        do_reset();
        load_delays(31, 31, 31, 31);
        for (int n = 0; n < 40; n++) begin
            run_frame(n, 0, 0, 0, 1'b0, s, lat);
            check($sformatf("wrap_f%0d", n), s, (n >= 31) ? n - 31 : 0);
        end

        // Overrun during ACCUM and delay load mid-frame
        do_reset();
        while (!ready_out) tick();
        set_audio(10, 20, 30, 40);
        audio_valid_in = 1'b1;
        tick();                                   // T+1
        audio_valid_in = 1'b0;
        tick();                                   // T+2
        check("ovr_before", overrun_out, 0);
        set_audio(999, 999, 999, 999);
        set_delays(1, 0, 0, 0);
        audio_valid_in = 1'b1;
        delay_load_in  = 1'b1;
        tick();                                   // T+3
        audio_valid_in = 1'b0;
        delay_load_in  = 1'b0;
        check("ovr_set", overrun_out, 1);
        tick();
        tick();
        tick();                                   // T+6
        check("ovr_inflight_valid", sum_valid_out, 1);
        check("ovr_inflight_sum", longint'(sum_out), 100);
        run_frame(1, 2, 3, 4, 1'b0, s, lat);
        check("no_gap_write", s, 19);
        check("ovr_sticky", overrun_out, 1);

        // Delay load coincident with accept applies to that frame
        set_delays(0, 0, 0, 0);
        run_frame(5, 6, 7, 8, 1'b1, s, lat);
        check("load_at_accept", s, 26);

        // Reset mid-ACCUM aborts the frame
        while (!ready_out) tick();
        set_audio(1, 1, 1, 1);
        audio_valid_in = 1'b1;
        tick();
        audio_valid_in = 1'b0;
        tick();
        do_reset();
        bad_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (sum_valid_out) bad_valid = 1'b1;
            tick();
        end
        check("abort_no_valid", bad_valid, 0);
        check("abort_overrun_clr", overrun_out, 0);
        check("abort_not_ready", ready_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
